// File: rtl/intellight_axil_regs.sv
// intellight_axil_regs
// AXI4-Lite responder register file for the intellight S00_AXI port. Holds
// NUM_REGS 32-bit read/write control registers, exposes them to the
// traffic-light core and pulses a per-register strobe on every committed write.
//
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   S_AXI_AW*              write address channel (AWPROT ignored)
//   S_AXI_W*               write data channel with byte strobes
//   S_AXI_B*               write response (00 OKAY, 10 SLVERR)
//   S_AXI_AR*              read address channel (ARPROT ignored)
//   S_AXI_R*               read data/response (00 OKAY, 10 SLVERR)
//   reg_out                register contents, reg i at [32i+31:32i]
//   reg_wr_pulse           bit i high for one cycle when reg i is written
module intellight_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_out,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    localparam int         IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;

    // Merge new data into an old word, lane by lane, under the byte strobes.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0]         regs_r [NUM_REGS];
    logic                aw_held_r;
    logic                w_held_r;
    logic [IDX_W-1:0]    aw_idx_r;
    logic [31:0]         w_data_r;
    logic [3:0]          w_strb_r;
    logic                awready_r;
    logic                wready_r;
    logic                bvalid_r;
    logic [1:0]          bresp_r;
    logic                arready_r;
    logic                rvalid_r;
    logic [31:0]         rdata_r;
    logic [1:0]          rresp_r;
    logic [NUM_REGS-1:0] pulse_r;

    logic                aw_hs_s;
    logic                w_hs_s;
    logic                ar_hs_s;
    logic                b_done_s;
    logic                r_done_s;
    logic                commit_s;
    logic                aw_held_nx_s;
    logic                w_held_nx_s;
    logic                bvalid_nx_s;
    logic                rvalid_nx_s;
    logic [IDX_W-1:0]    ar_idx_s;
    logic [NUM_REGS-1:0] wr_sel_s;
    logic                wr_hit_s;
    logic [31:0]         rd_data_s;
    logic                rd_hit_s;
    logic                unused_ok_s;

    // Protection bits and the byte offset inside a word carry no meaning here.
    assign unused_ok_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Handshake qualifiers and next-state of the hold/valid flags; READYs are
    // registered from these next-state values so they track the flags exactly.
    always_comb begin
        aw_hs_s      = S_AXI_AWVALID && awready_r;
        w_hs_s       = S_AXI_WVALID && wready_r;
        ar_hs_s      = S_AXI_ARVALID && arready_r;
        b_done_s     = bvalid_r && S_AXI_BREADY;
        r_done_s     = rvalid_r && S_AXI_RREADY;
        commit_s     = aw_held_r && w_held_r;
        aw_held_nx_s = aw_hs_s || (aw_held_r && !commit_s);
        w_held_nx_s  = w_hs_s || (w_held_r && !commit_s);
        bvalid_nx_s  = commit_s || (bvalid_r && !b_done_s);
        rvalid_nx_s  = ar_hs_s || (rvalid_r && !r_done_s);
        ar_idx_s     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end

    // Index decode: out-of-range indices match no register, which yields the
    // SLVERR responses and leaves every register untouched.
    always_comb begin
        wr_sel_s  = {NUM_REGS{1'b0}};
        rd_data_s = 32'h0000_0000;
        rd_hit_s  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel_s[i] = commit_s && (aw_idx_r == i[IDX_W-1:0]);
            rd_data_s   = rd_data_s | ((ar_idx_s == i[IDX_W-1:0]) ? regs_r[i] : 32'h0000_0000);
            rd_hit_s    = rd_hit_s | (ar_idx_s == i[IDX_W-1:0]);
        end
        wr_hit_s = |wr_sel_s;
    end

    // Register array: strobed byte-lane update on commit.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= wr_sel_s[i] ? merge_bytes(regs_r[i], w_data_r, w_strb_r) : regs_r[i];
            end
        end
    end

    // Write path: independent AW/W holding, commit, response and strobe.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_idx_r  <= {IDX_W{1'b0}};
            w_data_r  <= 32'h0000_0000;
            w_strb_r  <= 4'h0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            pulse_r   <= {NUM_REGS{1'b0}};
        end else begin
            aw_held_r <= aw_held_nx_s;
            w_held_r  <= w_held_nx_s;
            if (aw_hs_s) begin
                aw_idx_r <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end else begin
                aw_idx_r <= aw_idx_r;
            end
            if (w_hs_s) begin
                w_data_r <= S_AXI_WDATA;
                w_strb_r <= S_AXI_WSTRB;
            end else begin
                w_data_r <= w_data_r;
                w_strb_r <= w_strb_r;
            end
            if (commit_s) begin
                bresp_r <= wr_hit_s ? RESP_OKAY : RESP_SLV;
            end else begin
                bresp_r <= bresp_r;
            end
            bvalid_r  <= bvalid_nx_s;
            awready_r <= !aw_held_nx_s && !bvalid_nx_s;
            wready_r  <= !w_held_nx_s && !bvalid_nx_s;
            pulse_r   <= wr_sel_s;
        end
    end

    // Read path: data captured at the AR handshake, so a same-edge write to
    // the same register is not yet visible.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
        end else begin
            if (ar_hs_s) begin
                rdata_r <= rd_data_s;
                rresp_r <= rd_hit_s ? RESP_OKAY : RESP_SLV;
            end else begin
                rdata_r <= rdata_r;
                rresp_r <= rresp_r;
            end
            rvalid_r  <= rvalid_nx_s;
            arready_r <= !rvalid_nx_s;
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign reg_wr_pulse  = pulse_r;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[32*g +: 32] = regs_r[g];
    end

endmodule
